pipe_wb_regfile: RTL and testbench

PIPE_WB_REGFILE -- requirements
Module: pipe_wb_regfile

---
 rtl/pipe_pkg.sv | 6 +
 rtl/pipe_regfile_core.sv | 32 +++
 rtl/pipe_wb_regfile.sv | 50 +++++
 tb/tb_pipe_wb_regfile.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline constants for the write-back stage and register file.
package pipe_pkg;
    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_ADDR_W = 5;
    localparam int ZERO_REG    = 0;
endpackage

// File: rtl/pipe_regfile_core.sv
// pipe_regfile_core: register storage with one write port and two asynchronous read ports.
module pipe_regfile_core
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int ADDR_W = PIPE_ADDR_W
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic [DATA_W-1:0] da,
    output logic [DATA_W-1:0] db
);
    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [NREG];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    assign da = mem[ra];
    assign db = mem[rb];
endmodule

// File: rtl/pipe_wb_regfile.sv
// pipe_wb_regfile: write-back mux, register file with same-cycle bypass, and retired-write counter.
module pipe_wb_regfile
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int ADDR_W = PIPE_ADDR_W
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              wwreg,
    input  logic              wm2reg,
    input  logic [DATA_W-1:0] wmo,
    input  logic [DATA_W-1:0] walu,
    input  logic [ADDR_W-1:0] wrn,
    input  logic [ADDR_W-1:0] rna,
    input  logic [ADDR_W-1:0] rnb,
    output logic [DATA_W-1:0] qa,
    output logic [DATA_W-1:0] qb,
    output logic [DATA_W-1:0] wdi,
    output logic [31:0]       wbcnt
);
    localparam logic [ADDR_W-1:0] R0 = ADDR_W'(ZERO_REG);

    logic              wr_en;
    logic [DATA_W-1:0] da, db;

    assign wdi   = wm2reg ? wmo : walu;
    assign wr_en = wwreg && (wrn != R0);

    pipe_regfile_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_core (
        .clock  (clock),
        .resetn (resetn),
        .we     (wr_en),
        .wa     (wrn),
        .wd     (wdi),
        .ra     (rna),
        .rb     (rnb),
        .da     (da),
        .db     (db)
    );

    // Bypass lets the ID stage see the write retiring this cycle before it lands.
    assign qa = (rna == R0) ? '0 : (wwreg && wrn == rna) ? wdi : da;
    assign qb = (rnb == R0) ? '0 : (wwreg && wrn == rnb) ? wdi : db;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) wbcnt <= '0;
        else if (wr_en) wbcnt <= wbcnt + 32'd1;
    end
endmodule

// File: tb/tb_pipe_wb_regfile.sv
// tb_pipe_wb_regfile: directed vectors with hand-computed expectations for pipe_wb_regfile.
module tb_pipe_wb_regfile;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        wwreg = 1'b0;
    logic        wm2reg = 1'b0;
    logic [31:0] wmo = '0;
    logic [31:0] walu = '0;
    logic [4:0]  wrn = '0;
    logic [4:0]  rna = '0;
    logic [4:0]  rnb = '0;
    logic [31:0] qa, qb, wdi, wbcnt;
    int checks = 0;
    int failures = 0;

    pipe_wb_regfile dut (
        .clock  (clock),
        .resetn (resetn),
        .wwreg  (wwreg),
        .wm2reg (wm2reg),
        .wmo    (wmo),
        .walu   (walu),
        .wrn    (wrn),
        .rna    (rna),
        .rnb    (rnb),
        .qa     (qa),
        .qb     (qb),
        .wdi    (wdi),
        .wbcnt  (wbcnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clock);
        wwreg = 1'b1;
        wm2reg = 1'b0;
        walu = d;
        wrn = a;
        @(posedge clock);
        #1 wwreg = 1'b0;
    endtask

    initial begin
        #12 resetn = 1'b1;
        // every address reads zero after reset
        for (int a = 0; a < 32; a++) begin
            rna = 5'(a);
            rnb = 5'(31 - a);
            #1;
            check("reset_qa", qa, 32'h0);
            check("reset_qb", qb, 32'h0);
        end
        check("reset_wbcnt", wbcnt, 32'h0);

        // ALU write-back with same-cycle bypass
        @(negedge clock);
        wwreg = 1'b1; wm2reg = 1'b0; walu = 32'h12345678; wmo = 32'h0; wrn = 5'd5; rna = 5'd5;
        #1;
        check("bypass_wdi", wdi, 32'h12345678);
        check("bypass_qa", qa, 32'h12345678);
        @(posedge clock);
        #1 wwreg = 1'b0; walu = 32'h0;
        #1;
        check("stored_r5", qa, 32'h12345678);
        check("cnt_after_r5", wbcnt, 32'd1);

        // write to r0 is discarded and not counted
        @(negedge clock);
        wwreg = 1'b1; wm2reg = 1'b1; wmo = 32'hDEADBEEF; walu = 32'h1; wrn = 5'd0; rna = 5'd0; rnb = 5'd5;
        #1;
        check("r0_wdi_mem", wdi, 32'hDEADBEEF);
        check("r0_qa", qa, 32'h0);
        check("r0_qb_other", qb, 32'h12345678);
        @(posedge clock);
        #1 wwreg = 1'b0;
        #1;
        check("r0_qa_after", qa, 32'h0);
        check("r0_cnt", wbcnt, 32'd1);

        // r7 write, dual read, and a disabled write leaves it intact
        write_reg(5'd7, 32'hA5A5A5A5);
        wrn = 5'd7; walu = 32'h0; wm2reg = 1'b0; rna = 5'd7; rnb = 5'd7;
        #1;
        check("r7_qa", qa, 32'hA5A5A5A5);
        check("r7_qb", qb, 32'hA5A5A5A5);
        @(posedge clock);
        #1;
        check("r7_hold", qa, 32'hA5A5A5A5);
        check("cnt_r7", wbcnt, 32'd2);

        // memory-sourced bypass on port B only
        @(negedge clock);
        wwreg = 1'b1; wm2reg = 1'b1; wmo = 32'h00000077; walu = 32'h1; wrn = 5'd7; rna = 5'd5; rnb = 5'd7;
        #1;
        check("mem_bypass_qb", qb, 32'h00000077);
        check("mem_bypass_qa_other", qa, 32'h12345678);
        @(posedge clock);
        #1 wwreg = 1'b0; wm2reg = 1'b0;
        #1;
        check("r7_mem_stored", qb, 32'h00000077);
        check("cnt_mem", wbcnt, 32'd3);

        // counter wraps at 2^32
        @(negedge clock);
        force dut.wbcnt = 32'hFFFFFFFF;
        #1 release dut.wbcnt;
        #1;
        check("cnt_preload", wbcnt, 32'hFFFFFFFF);
        write_reg(5'd9, 32'h00000009);
        rna = 5'd9;
        #1;
        check("cnt_wrap", wbcnt, 32'h0);
        check("r9_stored", qa, 32'h00000009);

        // reset asserted mid-cycle during a pending write
        write_reg(5'd3, 32'h00000033);
        rna = 5'd3;
        #1;
        check("r3_before_reset", qa, 32'h00000033);
        check("cnt_before_reset", wbcnt, 32'd1);
        @(negedge clock);
        wwreg = 1'b1; wm2reg = 1'b0; walu = 32'h44; wrn = 5'd3; rna = 5'd3; rnb = 5'd7;
        #2 resetn = 1'b0;
        #1;
        check("rst_cnt_now", wbcnt, 32'h0);
        check("rst_bypass_qa", qa, 32'h44);
        check("rst_qb_cleared", qb, 32'h0);
        @(posedge clock);
        #1;
        check("rst_cnt_edge", wbcnt, 32'h0);
        wwreg = 1'b0;
        #1;
        check("rst_r3_now", qa, 32'h0);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        check("rel_r3", qa, 32'h0);
        check("rel_cnt", wbcnt, 32'h0);
        @(posedge clock);
        #1;
        check("rel_r3_edge", qa, 32'h0);
        check("rel_cnt_edge", wbcnt, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
